// File: rtl/space_monsters_pkg.sv
// space_monsters_pkg
// Shared definitions for the enemy fire scheduler.
//   - fs_state_e : one-hot scheduler states
//   - N_MON_DEF  : default monster count
//   - CD_L1_DEF / CD_L2_DEF : default per-level cooldowns, in frames
//   - cd_for_level() : selects the cooldown reload value for a level
package space_monsters_pkg;

    localparam int N_MON_DEF = 5;
    localparam int CD_L1_DEF = 60;
    localparam int CD_L2_DEF = 30;

    typedef enum logic [3:0] {
        FS_IDLE = 4'b0001,
        FS_COOL = 4'b0010,
        FS_SEL  = 4'b0100,
        FS_REQ  = 4'b1000
    } fs_state_e;

    function automatic logic [7:0] cd_for_level(input logic lvl, input int cd1, input int cd2);
        return lvl ? 8'(cd2) : 8'(cd1);
    endfunction

endpackage

// File: rtl/monster_fire_scheduler_rr_pick.sv
// rr_pick
// Combinational round-robin first-set finder. Searches mask_i starting at
// last_i+1 and wrapping modulo N. With last_i = N-1 it returns the
// lowest set bit, which makes it usable as a plain priority encoder.
// Ports:
//   mask_i  [N]  : candidate mask
//   last_i  [LW] : previous winner; the search starts just after it
//   valid_o      : some bit of mask_i is set
//   idx_o   [LW] : index of the winner (0 when valid_o is low)
module rr_pick
    import space_monsters_pkg::*;
#(
    parameter int N  = N_MON_DEF,
    parameter int LW = 3
) (
    input  logic [N-1:0]  mask_i,
    input  logic [LW-1:0] last_i,
    output logic          valid_o,
    output logic [LW-1:0] idx_o
);

    int pos;

    // Walk from the farthest position back to the nearest so the nearest
    // set bit is the last one written and therefore wins.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        pos     = 0;
        for (int k = N; k >= 1; k--) begin
            pos = (int'(last_i) + k) % N;
            if (((mask_i >> pos) & N'(1)) != '0) begin
                valid_o = 1'b1;
                idx_o   = LW'(pos);
            end
        end
    end

endmodule

// File: rtl/monster_fire_scheduler.sv
// monster_fire_scheduler
// Decides when an enemy monster fires and which one, then requests an
// enemy bullet slot from the bullet datapath over a req/ack handshake.
// Shooters are picked round-robin among live monsters; shots are paced by
// a per-level frame cooldown; enemy bullet slot occupancy is tracked here.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FS_IDLE | game not running; slot tracking flushed; loads cooldown on run
// FS_COOL | counting frame ticks down to zero
// FS_SEL  | looking for a live shooter and a free slot
// FS_REQ  | fire_req held with stable monster/slot until fire_ack
//
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   run_i                : high during L1/L2; low returns to idle
//   level_i              : 0 = L1, 1 = L2; sampled at each cooldown reload
//   frame_tick_i         : one pulse per video frame
//   alive_i     [N_MON]  : live-monster mask
//   slot_free_i [NSLOT]  : per-slot pulse when a bullet expires or hits
//   fire_ack_i           : datapath accepted the request
//   fire_req_o           : launch request
//   fire_mon_o  [MW]     : shooting monster
//   fire_slot_o [SW]     : target slot
//   slot_busy_o [NSLOT]  : slot occupancy mask
//   shots_o     [8]      : shots fired, wrapping
module monster_fire_scheduler
    import space_monsters_pkg::*;
#(
    parameter int N_MON = N_MON_DEF,
    parameter int NSLOT = 2,
    parameter int CD_L1 = CD_L1_DEF,
    parameter int CD_L2 = CD_L2_DEF,
    localparam int MW   = $clog2(N_MON),
    localparam int SW   = (NSLOT > 1) ? $clog2(NSLOT) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic             level_i,
    input  logic             frame_tick_i,
    input  logic [N_MON-1:0] alive_i,
    input  logic [NSLOT-1:0] slot_free_i,
    input  logic             fire_ack_i,
    output logic             fire_req_o,
    output logic [MW-1:0]    fire_mon_o,
    output logic [SW-1:0]    fire_slot_o,
    output logic [NSLOT-1:0] slot_busy_o,
    output logic [7:0]       shots_o
);

    fs_state_e        state_q, state_d;
    logic [7:0]       cd_q, cd_d;
    logic [MW-1:0]    last_q, last_d;
    logic             fire_req_q, fire_req_d;
    logic [MW-1:0]    fire_mon_q, fire_mon_d;
    logic [SW-1:0]    fire_slot_q, fire_slot_d;
    logic [NSLOT-1:0] slot_busy_q, slot_busy_d;
    logic [7:0]       shots_q, shots_d;

    logic             mon_valid;
    logic [MW-1:0]    mon_idx;
    logic             slot_valid;
    logic [SW-1:0]    slot_idx;
    logic [7:0]       cd_reload;

    assign cd_reload = cd_for_level(level_i, CD_L1, CD_L2);

    rr_pick #(.N(N_MON), .LW(MW)) u_mon_pick (
        .mask_i  (alive_i),
        .last_i  (last_q),
        .valid_o (mon_valid),
        .idx_o   (mon_idx)
    );

    // Pointer pinned at the top index turns the round-robin search into a
    // lowest-free-slot search.
    rr_pick #(.N(NSLOT), .LW(SW)) u_slot_pick (
        .mask_i  (~slot_busy_q),
        .last_i  (SW'(NSLOT - 1)),
        .valid_o (slot_valid),
        .idx_o   (slot_idx)
    );

    always_comb begin
        state_d     = state_q;
        cd_d        = cd_q;
        last_d      = last_q;
        fire_req_d  = fire_req_q;
        fire_mon_d  = fire_mon_q;
        fire_slot_d = fire_slot_q;
        shots_d     = shots_q;
        // Freeing applies first so an ack to another slot in the same
        // cycle still lands; freeing an idle slot is a no-op.
        slot_busy_d = slot_busy_q & ~slot_free_i;

        if (!run_i) begin
            // Leaving the game wins over everything, including an ack
            // arriving in the same cycle.
            state_d     = FS_IDLE;
            fire_req_d  = 1'b0;
            slot_busy_d = '0;
        end else begin
            case (state_q)
                FS_IDLE: begin
                    slot_busy_d = '0;
                    cd_d        = cd_reload;
                    state_d     = FS_COOL;
                end
                FS_COOL: begin
                    if (cd_q == 8'd0) begin
                        state_d = FS_SEL;
                    end else if (frame_tick_i) begin
                        cd_d = cd_q - 8'd1;
                    end
                end
                FS_SEL: begin
                    if (mon_valid && slot_valid) begin
                        fire_mon_d  = mon_idx;
                        fire_slot_d = slot_idx;
                        fire_req_d  = 1'b1;
                        state_d     = FS_REQ;
                    end
                end
                FS_REQ: begin
                    // The request is never retracted if the shooter dies.
                    if (fire_ack_i) begin
                        slot_busy_d = slot_busy_d | (NSLOT'(1) << fire_slot_q);
                        last_d      = fire_mon_q;
                        shots_d     = shots_q + 8'd1;
                        cd_d        = cd_reload;
                        fire_req_d  = 1'b0;
                        state_d     = FS_COOL;
                    end
                end
                default: begin
                    state_d     = FS_IDLE;
                    fire_req_d  = 1'b0;
                    slot_busy_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= FS_IDLE;
            cd_q        <= 8'd0;
            last_q      <= MW'(N_MON - 1);
            fire_req_q  <= 1'b0;
            fire_mon_q  <= '0;
            fire_slot_q <= '0;
            slot_busy_q <= '0;
            shots_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            cd_q        <= cd_d;
            last_q      <= last_d;
            fire_req_q  <= fire_req_d;
            fire_mon_q  <= fire_mon_d;
            fire_slot_q <= fire_slot_d;
            slot_busy_q <= slot_busy_d;
            shots_q     <= shots_d;
        end
    end

    assign fire_req_o  = fire_req_q;
    assign fire_mon_o  = fire_mon_q;
    assign fire_slot_o = fire_slot_q;
    assign slot_busy_o = slot_busy_q;
    assign shots_o     = shots_q;

endmodule

// File: doc/monster_fire_scheduler.md
# monster_fire_scheduler

- Decides when an enemy monster fires and which monster fires, then requests an enemy bullet slot from the bullet datapath.
- Sits beside `block_controller` and is enabled by the game state machine during L1/L2.
- Picks shooters round-robin among live monsters, paces shots with a per-level frame cooldown and tracks occupancy of the enemy bullet slots.
- Uses a req/ack handshake toward the bullet datapath.

## Interface
Parameters:
- `N_MON`, 5, number of monsters; index width `MW = $clog2(N_MON)`
- `NSLOT`, 2, enemy bullet slots; index width `SW = max(1, $clog2(NSLOT))`
- `CD_L1`, 60, cooldown in frames for level 0 (8-bit, 1..255)
- `CD_L2`, 30, cooldown in frames for level 1 (8-bit, 1..255)

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset. Asynchronous, active-low.
- `run` in 1: high while the game is in L1/L2. Low means idle and flushes slot tracking.
- `level` in 1: 0 = L1, 1 = L2. Sampled at each cooldown reload.
- `frame_tick` in 1: one-cycle pulse per video frame.
- `alive` in N_MON: live-monster mask (`~monster_destroyed`).
- `slot_free` in NSLOT: one-cycle pulse per slot whose bullet has expired or hit.
- `fire_ack` in 1: bullet datapath accepted the request.
- `fire_req` out 1: request to launch an enemy bullet.
- `fire_mon` out MW: shooting monster index. Stable while `fire_req` is high.
- `fire_slot` out SW: target slot index. Stable while `fire_req` is high.
- `slot_busy` out NSLOT: occupancy mask.
- `shots` out 8: shots fired, wraps 255 -> 0.

## Operation
States (one-hot): `IDLE`, `COOL`, `SEL`, `REQ`.

- **Reset values:**
  - state = IDLE
  - `fire_req` = 0, `fire_mon` = 0, `fire_slot` = 0
  - `slot_busy` = 0, `shots` = 0
  - cooldown counter `cd` = 0
  - round-robin pointer `last` = N_MON-1, so monster 0 has first priority
- **IDLE:**
  - `slot_busy` is cleared every cycle.
  - On `run` = 1: load `cd` = level ? CD_L2 : CD_L1, then go to COOL.
- **COOL:**
  - If `cd` = 0, go to SEL.
  - Otherwise, on `frame_tick`, `cd` <= `cd` - 1.
- **SEL:**
  - Candidate monster: the first set bit of `alive` searching `last`+1, `last`+2, … with modulo-N_MON wrap.
  - Candidate slot: the lowest-index clear bit of `slot_busy`.
  - If both exist: register `fire_mon`/`fire_slot`, set `fire_req`, go to REQ.
  - Otherwise stay in SEL and re-evaluate every cycle.
- **REQ:**
  - Hold `fire_req`, `fire_mon` and `fire_slot` until `fire_ack` is sampled high.
  - In the ack cycle:
    - `slot_busy[fire_slot]` <= 1
    - `last` <= `fire_mon`
    - `shots` <= `shots` + 1
    - `cd` reloads for the current `level`
    - `fire_req` drops at the next edge; state goes to COOL
  - A monster dying while its request is pending does not retract the request.
- **`slot_free` handling:**
  - A `slot_free[i]` pulse clears `slot_busy[i]` in any non-IDLE state.
  - A pulse on a non-busy slot is ignored.
  - A `slot_free` pulse and an ack to a different slot in the same cycle both take effect.
- **`run` dropping** in any state: go to IDLE at the next edge. `fire_req` is 0 from that edge; an ack in that same cycle is ignored.
- **`alive` = 0** (level cleared): stay in SEL with no request until `run` drops.

## Timing
- Cooldown is exactly CD `frame_tick` pulses from the ack until `cd` reaches 0.
- `fire_req` rises 2 cycles after the edge at which `cd` becomes 0 (COOL -> SEL -> REQ), provided a candidate monster and a free slot exist.
- Throughput: at most one shot per cooldown. `fire_ack` may arrive any number of cycles after `fire_req`.
- A `frame_tick` during SEL or REQ is not counted.
- Asynchronous reset mid-request drops `fire_req` immediately.

## Structure
- Shared package `space_monsters_pkg` holds:
  - one-hot state encodings `FS_IDLE`, `FS_COOL`, `FS_SEL`, `FS_REQ`
  - `N_MON_DEF` = 5
  - `CD_L1_DEF` / `CD_L2_DEF`
- Sub-module `rr_pick`: combinational round-robin first-set finder. Takes mask (N_MON), `last` (MW); produces `valid`, `idx`. It is reusable for the lowest-free-slot search when `last` = NSLOT-1.

## Test plan
- CD_L1 = 3, `alive` = 11111, `run` held, `fire_ack` 1 cycle after `fire_req`, slots freed 2 cycles after ack:
  - `fire_mon` sequence = 0, 1, 2, 3, 4, 0
  - exactly 3 ticks between shots
  - `shots` counts to 6
- `alive` = 10101, `last` = 0 -> `fire_mon` = 2, then 4, then 0; dead monsters are never picked.
- Both slots busy, no `slot_free` -> `fire_req` stays 0 in SEL. A `slot_free[1]` pulse -> `fire_req` rises 1 cycle later with `fire_slot` = 1.
- `level` = 1, CD_L2 = 2 -> shot interval is 2 frames. Switching `level` mid-cooldown takes effect only at the next reload.
- `fire_ack` withheld 10 cycles while the chosen monster's `alive` bit falls -> `fire_req`, `fire_mon` and `fire_slot` are unchanged throughout.
- `run` drops during REQ -> `fire_req` = 0 and `slot_busy` = 0 on the following cycle. Asserting `rst` low mid-request -> all outputs at their reset values immediately.
